wr_resp_monitor: RTL

Passive monitor placed beside the AXI write engine on the same AXI master port. It timestamps each write-address handshake and matches it, in order, against the write-response (B) handshakes. From this it accumulates per-transaction write latency (AW accept to B accept), response and error counts, and min/max latency. It signals completion to the benchmark control logic once the configured number of responses has been received.

---
 rtl/wr_resp_monitor.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wr_resp_monitor.sv
// Passive AXI write-response monitor: timestamps AW handshakes and matches them in order
// against B handshakes to gather latency/response statistics. Optional: WR_RESP_ID_CHECK_EN.
module wr_resp_monitor #(
    parameter int unsigned ID_WIDTH   = 5,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned TS_WIDTH   = 32
`ifdef WR_RESP_ID_CHECK_EN
    ,
    parameter logic [ID_WIDTH-1:0] EXP_ID = '0
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [63:0]         num_ops,
    input  logic                m_axi_AWVALID,
    input  logic                m_axi_AWREADY,
    input  logic                m_axi_BVALID,
    input  logic                m_axi_BREADY,
    input  logic [1:0]          m_axi_BRESP,
    input  logic [ID_WIDTH-1:0] m_axi_BID,
    output logic                done,
    output logic [63:0]         resp_cnt,
    output logic [31:0]         err_cnt,
    output logic [31:0]         orphan_cnt,
    output logic [63:0]         lat_sum,
    output logic [TS_WIDTH-1:0] lat_min,
    output logic [TS_WIDTH-1:0] lat_max,
    output logic                ovf
`ifdef WR_RESP_ID_CHECK_EN
    ,
    output logic [31:0]         id_err_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]        C_DEPTH   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]        C_CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]      C_PTR_ONE = PTR_W'(1);
    localparam logic [TS_WIDTH-1:0]   C_TS_ONE  = TS_WIDTH'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [63:0]           r_num_ops;
    logic [TS_WIDTH-1:0]   r_ts;
    logic [TS_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;

    logic                  r_done;
    logic [63:0]           r_resp_cnt;
    logic [31:0]           r_err_cnt;
    logic [31:0]           r_orphan_cnt;
    logic [63:0]           r_lat_sum;
    logic [TS_WIDTH-1:0]   r_lat_min;
    logic [TS_WIDTH-1:0]   r_lat_max;
    logic                  r_ovf;

    logic                  w_active;
    logic                  w_aw_fire;
    logic                  w_b_fire;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic [TS_WIDTH-1:0]   w_lat;
    logic [63:0]           w_resp_nxt;
    logic                  w_last_b;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else if (w_last_b) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs; a start cycle in RUN discards the handshakes it sees
    always_comb begin
        w_active = 1'b0;
        unique case (r_state)
            S_IDLE:  w_active = 1'b0;
            S_RUN:   w_active = !start;
            default: w_active = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake qualification and FIFO control
    // ------------------------------------------------------------------
    assign w_aw_fire  = m_axi_AWVALID & m_axi_AWREADY & w_active;
    assign w_b_fire   = m_axi_BVALID  & m_axi_BREADY  & w_active;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_DEPTH);
    assign w_pop      = w_b_fire & !w_empty;
    // A concurrent pop frees the slot, so a push into a full FIFO still succeeds
    assign w_push     = w_aw_fire & (!w_full | w_pop);
    assign w_lat      = r_ts - r_mem[r_rd_ptr];
    assign w_resp_nxt = r_resp_cnt + 64'd1;
    assign w_last_b   = w_b_fire && (w_resp_nxt == r_num_ops);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_ts;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: timestamp, FIFO pointers, statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_num_ops    <= '0;
            r_ts         <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_done       <= 1'b0;
            r_resp_cnt   <= '0;
            r_err_cnt    <= '0;
            r_orphan_cnt <= '0;
            r_lat_sum    <= '0;
            r_lat_min    <= '1;
            r_lat_max    <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_done <= w_last_b;
            if (start) begin
                r_num_ops    <= num_ops;
                r_ts         <= '0;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_count      <= '0;
                r_resp_cnt   <= '0;
                r_err_cnt    <= '0;
                r_orphan_cnt <= '0;
                r_lat_sum    <= '0;
                r_lat_min    <= '1;
                r_lat_max    <= '0;
                r_ovf        <= 1'b0;
            end else if (w_active) begin
                r_ts <= r_ts + C_TS_ONE;

                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + C_CNT_ONE;
                    2'b01:   r_count <= r_count - C_CNT_ONE;
                    default: r_count <= r_count;
                endcase

                if (w_aw_fire && !w_push) begin
                    r_ovf <= 1'b1;
                end

                if (w_b_fire) begin
                    r_resp_cnt <= w_resp_nxt;
                    if ((m_axi_BRESP != 2'b00) && (r_err_cnt != '1)) begin
                        r_err_cnt <= r_err_cnt + 32'd1;
                    end
                    if (w_empty) begin
                        if (r_orphan_cnt != '1) begin
                            r_orphan_cnt <= r_orphan_cnt + 32'd1;
                        end
                    end else begin
                        r_lat_sum <= r_lat_sum + 64'(w_lat);
                        if (w_lat < r_lat_min) begin
                            r_lat_min <= w_lat;
                        end
                        if (w_lat > r_lat_max) begin
                            r_lat_max <= w_lat;
                        end
                    end
                end
            end
        end
    end

`ifdef WR_RESP_ID_CHECK_EN
    logic [31:0] r_id_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id_err_cnt <= '0;
        end else if (start) begin
            r_id_err_cnt <= '0;
        end else if (w_b_fire && (m_axi_BID != EXP_ID) && (r_id_err_cnt != '1)) begin
            r_id_err_cnt <= r_id_err_cnt + 32'd1;
        end
    end

    assign id_err_cnt = r_id_err_cnt;
`else
    logic w_unused_bid;
    assign w_unused_bid = ^m_axi_BID;
`endif

    assign done       = r_done;
    assign resp_cnt   = r_resp_cnt;
    assign err_cnt    = r_err_cnt;
    assign orphan_cnt = r_orphan_cnt;
    assign lat_sum    = r_lat_sum;
    assign lat_min    = r_lat_min;
    assign lat_max    = r_lat_max;
    assign ovf        = r_ovf;

endmodule
